// File: rtl/svm_pkg.sv
// Shared constants and state encoding for the SVM instruction fetch path.
package svm_pkg;

   localparam int ROM_FIFO_DATA_WIDTH         = 8;
   localparam int NUM_OF_ROM_FIFO_RD_PER_INST = 4;
   localparam int IEEE_32BIT                  = 32;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_DRAIN,
      ST_DONE
   } t_rom_dma_fetch_st;

endpackage

// File: rtl/rom_data_fifo.sv
// Synchronous first-word-fall-through FIFO; the head entry is visible on o_data
// the cycle after it is written, and reads as zero while the FIFO is empty.
module rom_data_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_data,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_data,
   output logic                       o_vld,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_level
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wrPtr;
   logic [PW-1:0]    r_rdPtr;
   logic [LW-1:0]    r_level;

   logic w_full;
   logic w_empty;
   logic w_doPush;
   logic w_doPop;

   assign w_full   = (r_level == LW'(DEPTH));
   assign w_empty  = (r_level == '0);
   assign w_doPush = i_push && !w_full;
   assign w_doPop  = i_pop && !w_empty;

   always_ff @(posedge clk) begin
      if (w_doPush) begin
         r_mem[r_wrPtr] <= i_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_level <= '0;
      end else begin
         if (w_doPush) begin
            r_wrPtr <= r_wrPtr + PW'(1);
         end
         if (w_doPop) begin
            r_rdPtr <= r_rdPtr + PW'(1);
         end
         case ({w_doPush, w_doPop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   assign o_data  = w_empty ? '0 : r_mem[r_rdPtr];
   assign o_vld   = !w_empty;
   assign o_full  = w_full;
   assign o_empty = w_empty;
   assign o_level = r_level;

endmodule

// File: rtl/rom_dma_fifo_fetch.sv
// Walks a ROM byte range through a fixed-latency read port into a FWFT FIFO,
// issuing reads only while FIFO occupancy plus outstanding reads leaves room.
module rom_dma_fifo_fetch #(
   parameter int ROM_ADDR_WIDTH      = 10,
   parameter int ROM_FIFO_DATA_WIDTH = svm_pkg::ROM_FIFO_DATA_WIDTH,
   parameter int ROM_FIFO_DEPTH      = 16,
   parameter int ROM_RD_LATENCY      = 2
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                start,
   input  logic [ROM_ADDR_WIDTH-1:0]           start_addr,
   input  logic [ROM_ADDR_WIDTH:0]             xfer_len,
   output logic                                busy,
   output logic                                done,
   output logic                                rom_rd_en,
   output logic [ROM_ADDR_WIDTH-1:0]           rom_rd_addr,
   input  logic [ROM_FIFO_DATA_WIDTH-1:0]      rom_rd_data,
   input  logic                                rom_data_fifo_fifo_data_pop,
   output logic [ROM_FIFO_DATA_WIDTH-1:0]      rom_data_fifo_fifo_data_out,
   output logic                                rom_data_fifo_fifo_data_out_vld,
   output logic                                rom_data_fifo_fifo_full,
   output logic                                rom_data_fifo_fifo_empty,
   output logic [$clog2(ROM_FIFO_DEPTH):0]     fifo_level
);

   import svm_pkg::*;

   localparam int LW = $clog2(ROM_FIFO_DEPTH) + 1;

   t_rom_dma_fetch_st            r_state;
   logic [ROM_ADDR_WIDTH-1:0]    r_addr;
   logic [ROM_ADDR_WIDTH:0]      r_remaining;
   logic [LW-1:0]                r_inFlight;
   logic [ROM_RD_LATENCY-1:0]    r_vldPipe;
   logic                         r_busy;
   logic                         r_done;

   logic                         w_issue;
   logic                         w_return;
   logic [LW:0]                  w_committed;

   // Every issued read already owns a FIFO slot, so a push can never find it full.
   assign w_committed = {1'b0, fifo_level} + {1'b0, r_inFlight};
   assign w_issue     = (r_state == ST_ISSUE) && (w_committed < (LW+1)'(ROM_FIFO_DEPTH));
   assign w_return    = r_vldPipe[ROM_RD_LATENCY-1];

   assign rom_rd_en   = w_issue;
   assign rom_rd_addr = r_addr;
   assign busy        = r_busy;
   assign done        = r_done;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_vldPipe  <= '0;
         r_inFlight <= '0;
      end else begin
         r_vldPipe[0] <= w_issue;
         for (int i = 1; i < ROM_RD_LATENCY; i++) begin
            r_vldPipe[i] <= r_vldPipe[i-1];
         end
         r_inFlight <= r_inFlight + LW'(w_issue) - LW'(w_return);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_addr      <= '0;
         r_remaining <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_busy <= 1'b1;
                  if (xfer_len != '0) begin
                     r_addr      <= start_addr;
                     r_remaining <= xfer_len;
                     r_state     <= ST_ISSUE;
                  end else begin
                     r_done  <= 1'b1;
                     r_state <= ST_DONE;
                  end
               end
            end
            ST_ISSUE: begin
               if (w_issue) begin
                  r_addr      <= r_addr + ROM_ADDR_WIDTH'(1);
                  r_remaining <= r_remaining - (ROM_ADDR_WIDTH+1)'(1);
                  if (r_remaining == (ROM_ADDR_WIDTH+1)'(1)) begin
                     r_state <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if ((r_inFlight == '0) && !w_return) begin
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   rom_data_fifo #(
      .WIDTH (ROM_FIFO_DATA_WIDTH),
      .DEPTH (ROM_FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_return),
      .i_data  (rom_rd_data),
      .i_pop   (rom_data_fifo_fifo_data_pop),
      .o_data  (rom_data_fifo_fifo_data_out),
      .o_vld   (rom_data_fifo_fifo_data_out_vld),
      .o_full  (rom_data_fifo_fifo_full),
      .o_empty (rom_data_fifo_fifo_empty),
      .o_level (fifo_level)
   );

endmodule

// File: doc/rom_dma_fifo_fetch.md
Name: rom_dma_fifo_fetch

Overview:
- Upstream fetch stage for the SVM instruction path.
- Walks a programmed ROM byte range through a fixed-latency synchronous ROM read port and pushes each returned byte into an internal first-word-fall-through FIFO.
- Exposes the rom_data_fifo_* pop/data/valid/full/empty interface consumed by the 32-bit instruction assembler.
- A credit scheme guarantees that FIFO overflow never occurs.

Parameters:
- ROM_ADDR_WIDTH, 10, ROM byte-address width; addresses wrap modulo 2^ROM_ADDR_WIDTH.
- ROM_FIFO_DATA_WIDTH, 8, ROM/FIFO word width.
- ROM_FIFO_DEPTH, 16, FIFO entries; power of 2, at least 4.
- ROM_RD_LATENCY, 2, cycles from rom_rd_en to a valid rom_rd_data; range 1..4.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle transfer request; sampled only in IDLE
- start_addr  in  ROM_ADDR_WIDTH  first ROM byte address
- xfer_len  in  ROM_ADDR_WIDTH+1  byte count, 0..2^ROM_ADDR_WIDTH
- busy  out  1  high from ISSUE through DONE
- done  out  1  one-cycle pulse after the last byte is written into the FIFO
- rom_rd_en  out  1  ROM read strobe
- rom_rd_addr  out  ROM_ADDR_WIDTH  ROM read address
- rom_rd_data  in  ROM_FIFO_DATA_WIDTH  valid exactly ROM_RD_LATENCY cycles after rom_rd_en
- rom_data_fifo_fifo_data_pop  in  1  pop the head entry
- rom_data_fifo_fifo_data_out  out  ROM_FIFO_DATA_WIDTH  head entry (FWFT); 0 when empty
- rom_data_fifo_fifo_data_out_vld  out  1  equals !empty
- rom_data_fifo_fifo_full  out  1  level == ROM_FIFO_DEPTH
- rom_data_fifo_fifo_empty  out  1  level == 0
- fifo_level  out  $clog2(ROM_FIFO_DEPTH)+1  current occupancy

Behaviour:
- Reset values:
  - busy=0, done=0, rom_rd_en=0, rom_rd_addr=0.
  - data_out=0, data_out_vld=0, full=0, empty=1, fifo_level=0.
  - FSM in IDLE; pointers, remaining-count, in-flight count and the return-valid shift register all cleared.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE:
    - start & xfer_len!=0: latch addr=start_addr and remaining=xfer_len, go to ISSUE.
    - start & xfer_len==0: go to DONE directly, with no ROM reads.
  - ISSUE:
    - Issue a read when (fifo_level + in_flight) < ROM_FIFO_DEPTH.
    - An issue sets rom_rd_en=1 and rom_rd_addr=addr (combinational from state/credit), then addr<=addr+1 with wrap and remaining<=remaining-1.
    - When the issue consumes the last byte (remaining==1), go to DRAIN.
    - Maximum rate is one read per cycle.
  - DRAIN: go to DONE when in_flight==0 and no return is arriving this cycle.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
  - start is ignored outside IDLE.
- Return path:
  - A ROM_RD_LATENCY-deep valid shift register is fed by rom_rd_en.
  - The tap at the end pushes rom_rd_data into the FIFO that cycle.
  - in_flight = count of set bits; updated as +issue −return per cycle.
- FIFO:
  - Write pointer, read pointer and level register.
  - Push and pop in the same cycle: level unchanged, both pointers advance.
  - Pop while empty: ignored, no pointer or level change.
  - A push while full cannot occur because of the credit rule; a bench assertion checks this.
  - Data written in cycle N is visible on data_out in cycle N+1.
- Latency: start at cycle 0 → first rom_rd_en at cycle 1 → first byte visible on data_out at cycle 1+ROM_RD_LATENCY+1.
- done timing:
  - done refers to FIFO writes, not to consumer pops.
  - Remaining FIFO data stays available after done.
- Reset mid-operation:
  - All state cleared next edge; the FIFO contents are discarded.
  - ROM data still in flight when reset is released is never pushed.

Decomposition:
- Shared package svm_pkg holds:
  - ROM_FIFO_DATA_WIDTH, NUM_OF_ROM_FIFO_RD_PER_INST, IEEE_32BIT;
  - the enum typedef t_rom_dma_fetch_st for the FSM states.
- One sub-module, rom_data_fifo: a synchronous FWFT FIFO parameterised by width and depth, providing push, pop, data_out, vld, full, empty and level.
- The FSM, credit logic and return pipeline live in the top module.

Test Plan:
- Basic transfer:
  - Stimulus: ROM content = addr[7:0]; start_addr=0x010, xfer_len=8; consumer pops whenever vld.
  - Required response: FIFO outputs 0x10..0x17 in order; rom_rd_en high 8 consecutive cycles; a single done pulse; busy then falls.
- Backpressure:
  - Stimulus: xfer_len=40, no pops.
  - Required response: fifo_level saturates at 16 with full=1; rom_rd_en stays 0 while level+in_flight==16.
  - Then pop continuously: all 40 bytes arrive in order with no loss or duplicates; the overflow assertion never fires.
- Address wrap:
  - Stimulus: start_addr=0x3FE, xfer_len=4.
  - Required response: rom_rd_addr sequence 0x3FE, 0x3FF, 0x000, 0x001; data order matches.
- Zero length:
  - Stimulus: start with xfer_len=0.
  - Required response: done pulses 1 cycle later; rom_rd_en never asserted; FIFO stays empty. A start pulsed during an active transfer is ignored.
- Reset mid-transfer:
  - Stimulus: assert reset for 1 cycle after 5 issues, with 2 reads in flight.
  - Required response: the next cycle shows empty=1, fifo_level=0, busy=0; late ROM data is not pushed. A new start (addr 0x020, len 4) then delivers 0x20..0x23.
- Pop edge cases:
  - Pop while empty: no change in fifo_level or pointers.
  - Simultaneous push and pop at level 1: level stays 1 and the head advances correctly.
